// File: rtl/seqmult_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = operand producer and result consumer; slave = the multiplier.
interface seqmult_if #(
    parameter int unsigned p_OPERAND_WIDTH = 4
) ();
    localparam int unsigned OPW  = p_OPERAND_WIDTH;
    localparam int unsigned PRODW = 2 * p_OPERAND_WIDTH;

    logic             i_VALID;
    logic             o_READY;
    logic [OPW-1:0]   i_MULTIPLICAND;
    logic [OPW-1:0]   i_MULTIPLIER;
    logic             o_VALID;
    logic             i_READY;
    logic [PRODW-1:0] o_PRODUCT;

    modport master (
        output i_VALID, i_MULTIPLICAND, i_MULTIPLIER, i_READY,
        input  o_READY, o_VALID, o_PRODUCT
    );

    modport slave (
        input  i_VALID, i_MULTIPLICAND, i_MULTIPLIER, i_READY,
        output o_READY, o_VALID, o_PRODUCT
    );
endinterface

// File: rtl/seqmult.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, full 2N-bit
// product, valid/ready on both sides with a single operation in flight.
module seqmult #(
    parameter int unsigned p_OPERAND_WIDTH = 4
) (
    input  logic      i_CLK,
    input  logic      i_RST_N,
    seqmult_if.slave  bus
);
    localparam int unsigned OPW   = p_OPERAND_WIDTH;
    localparam int unsigned PRODW = 2 * p_OPERAND_WIDTH;
    localparam int unsigned CNTW  = (OPW > 1) ? $clog2(OPW) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(OPW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [PRODW-1:0] mcand_q,   mcand_d;
    logic [OPW-1:0]   mplier_q,  mplier_d;
    logic [PRODW-1:0] acc_q,     acc_d;
    logic [CNTW-1:0]  cnt_q,     cnt_d;
    logic [PRODW-1:0] product_q, product_d;
    logic             ready_q,   ready_d;
    logic             valid_q,   valid_d;
    logic [PRODW-1:0] sum_c;

    // Accumulator plus this step's partial product; never exceeds 2N bits.
    assign sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ready_d   = ready_q;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_VALID) begin
                    state_d  = S_RUN;
                    mcand_d  = PRODW'(bus.i_MULTIPLICAND);
                    mplier_d = bus.i_MULTIPLIER;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                end
            end
            S_RUN: begin
                acc_d    = sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // Terminal step publishes the product including its own partial product.
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    product_d = sum_c;
                    valid_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DONE: begin
                if (bus.i_READY) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.o_READY   = ready_q;
    assign bus.o_VALID   = valid_q;
    assign bus.o_PRODUCT = product_q;
endmodule

// File: tb/tb_seqmult.sv
// Self-checking bench for seqmult: directed scenarios plus a shuffled sweep of
// every operand pair against a plain-arithmetic product/latency model.
module tb_seqmult;
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2 * N;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    seqmult_if #(.p_OPERAND_WIDTH(N)) bus ();

    seqmult #(.p_OPERAND_WIDTH(N)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return PW'(p);
    endfunction

    // Drive one operand pair and wait (bounded) for o_VALID; leaves the DUT in DONE.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit release_rst,
                         output int lat, output logic [PW-1:0] prod, output bit rdy_in_run,
                         output int acc_cyc);
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        bus.i_VALID        = 1'b1;
        bus.i_MULTIPLICAND = a;
        bus.i_MULTIPLIER   = b;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        bus.i_VALID = 1'b0;
        rdy_in_run  = 1'b0;
        lat         = 0;
        while (!bus.o_VALID && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.o_READY) rdy_in_run = 1'b1;
        end
        prod = bus.o_PRODUCT;
    endtask

    task automatic release_result();
        bus.i_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.i_READY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_VALID = 1'b0; bus.i_READY = 1'b0;
        bus.i_MULTIPLICAND = '0; bus.i_MULTIPLIER = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_READY !== 1'b1 || bus.o_VALID !== 1'b0 || bus.o_PRODUCT !== PW'(0)) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b prod=%h, want 1 0 00",
                     bus.o_READY, bus.o_VALID, bus.o_PRODUCT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.o_READY !== 1'b1 || bus.o_VALID !== 1'b0 || bus.o_PRODUCT !== PW'(0)) begin
                failures++;
                $display("FAIL idle_hold[%0d]: ready=%b valid=%b prod=%h, want 1 0 00",
                         i, bus.o_READY, bus.o_VALID, bus.o_PRODUCT);
            end
        end
    endtask

    task automatic test_max();
        int lat, acc; logic [PW-1:0] prod; bit rdy;
        do_op(4'hF, 4'hF, 1'b0, lat, prod, rdy, acc);
        checks++;
        if (prod !== ref_mul(4'hF, 4'hF) || lat != int'(N) || rdy) begin
            failures++;
            $display("FAIL max_operands: prod=%h lat=%0d ready_in_run=%b, want %h %0d 0",
                     prod, lat, rdy, ref_mul(4'hF, 4'hF), N);
        end
        release_result();
    endtask

    task automatic test_zero_identity();
        logic [N-1:0] as [3];
        logic [N-1:0] bs [3];
        int lat, acc; logic [PW-1:0] prod; bit rdy;
        as[0] = 4'h0; bs[0] = 4'hB;
        as[1] = 4'h7; bs[1] = 4'h1;
        as[2] = 4'h1; bs[2] = 4'h9;
        for (int i = 0; i < 3; i++) begin
            do_op(as[i], bs[i], 1'b0, lat, prod, rdy, acc);
            checks++;
            if (prod !== ref_mul(as[i], bs[i]) || lat != int'(N) || rdy) begin
                failures++;
                $display("FAIL zero_identity %h*%h: prod=%h lat=%0d, want %h %0d",
                         as[i], bs[i], prod, lat, ref_mul(as[i], bs[i]), N);
            end
            release_result();
            checks++;
            if (bus.o_READY !== 1'b1 || bus.o_VALID !== 1'b0) begin
                failures++;
                $display("FAIL result_handshake[%0d]: ready=%b valid=%b, want 1 0",
                         i, bus.o_READY, bus.o_VALID);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, acc; logic [PW-1:0] prod; bit rdy;
        do_op(4'hA, 4'h6, 1'b0, lat, prod, rdy, acc);
        checks++;
        if (prod !== ref_mul(4'hA, 4'h6) || lat != int'(N)) begin
            failures++;
            $display("FAIL bp_result: prod=%h lat=%0d, want %h %0d", prod, lat, ref_mul(4'hA, 4'h6), N);
        end
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.o_VALID !== 1'b1 || bus.o_READY !== 1'b0 || bus.o_PRODUCT !== ref_mul(4'hA, 4'h6)) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b prod=%h, want 1 0 %h",
                         i, bus.o_VALID, bus.o_READY, bus.o_PRODUCT, ref_mul(4'hA, 4'h6));
            end
        end
        release_result();
        checks++;
        if (bus.o_READY !== 1'b1 || bus.o_VALID !== 1'b0 || bus.o_PRODUCT !== ref_mul(4'hA, 4'h6)) begin
            failures++;
            $display("FAIL bp_release: ready=%b valid=%b prod=%h, want 1 0 %h",
                     bus.o_READY, bus.o_VALID, bus.o_PRODUCT, ref_mul(4'hA, 4'h6));
        end
    endtask

    task automatic test_back_to_back();
        int lat, acc0, acc1;
        @(negedge clk);
        bus.i_VALID = 1'b1; bus.i_MULTIPLICAND = 4'h3; bus.i_MULTIPLIER = 4'h5;
        @(posedge clk);
        #1;
        acc0 = cyc;
        lat  = 0;
        // Operand, valid and ready noise while running must have no effect.
        while (!bus.o_VALID && lat < 50) begin
            bus.i_VALID = 1'($urandom_range(0, 1));
            bus.i_READY = 1'($urandom_range(0, 1));
            bus.i_MULTIPLICAND = 4'hF; bus.i_MULTIPLIER = 4'hF;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.o_PRODUCT !== ref_mul(4'h3, 4'h5) || lat != int'(N)) begin
            failures++;
            $display("FAIL ignored_inputs: prod=%h lat=%0d, want %h %0d",
                     bus.o_PRODUCT, lat, ref_mul(4'h3, 4'h5), N);
        end
        bus.i_READY = 1'b1;
        bus.i_VALID = 1'b1; bus.i_MULTIPLICAND = 4'h2; bus.i_MULTIPLIER = 4'h2;
        @(posedge clk);
        #1;
        bus.i_READY = 1'b0;
        checks++;
        if (bus.o_VALID !== 1'b0 || bus.o_READY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_eh: valid=%b ready=%b, want 0 1", bus.o_VALID, bus.o_READY);
        end
        @(posedge clk);
        #1;
        acc1 = cyc;
        bus.i_VALID = 1'b0;
        checks++;
        if (bus.o_READY !== 1'b0 || (acc1 - acc0) != int'(N + 2)) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b interval=%0d, want 0 %0d", bus.o_READY, acc1 - acc0, N + 2);
        end
        lat = 0;
        while (!bus.o_VALID && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.o_PRODUCT !== ref_mul(4'h2, 4'h2) || lat != int'(N)) begin
            failures++;
            $display("FAIL b2b_result: prod=%h lat=%0d, want %h %0d",
                     bus.o_PRODUCT, lat, ref_mul(4'h2, 4'h2), N);
        end
        release_result();
    endtask

    task automatic test_async_reset();
        int lat, acc; logic [PW-1:0] prod; bit rdy;
        @(negedge clk);
        bus.i_VALID = 1'b1; bus.i_MULTIPLICAND = 4'hC; bus.i_MULTIPLIER = 4'hD;
        @(posedge clk);
        #1;
        bus.i_VALID = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_READY !== 1'b1 || bus.o_VALID !== 1'b0 || bus.o_PRODUCT !== PW'(0)) begin
            failures++;
            $display("FAIL async_reset: ready=%b valid=%b prod=%h, want 1 0 00",
                     bus.o_READY, bus.o_VALID, bus.o_PRODUCT);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.o_VALID !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_valid[%0d]: valid=%b, want 0", i, bus.o_VALID);
            end
        end
        do_op(4'hC, 4'hD, 1'b1, lat, prod, rdy, acc);
        checks++;
        if (prod !== ref_mul(4'hC, 4'hD) || lat != int'(N) || rdy) begin
            failures++;
            $display("FAIL after_reset: prod=%h lat=%0d ready_in_run=%b, want %h %0d 0",
                     prod, lat, rdy, ref_mul(4'hC, 4'hD), N);
        end
        release_result();
    endtask

    task automatic test_random_sweep();
        int order [256];
        int lat, acc, tmp, j;
        logic [PW-1:0] prod; bit rdy;
        logic [N-1:0] a, b;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            a = N'(order[i] >> 4);
            b = N'(order[i]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(a, b, 1'b0, lat, prod, rdy, acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            checks++;
            if (bus.o_PRODUCT !== ref_mul(a, b) || prod !== ref_mul(a, b) || lat != int'(N) || rdy
                || bus.o_VALID !== 1'b1) begin
                failures++;
                $display("FAIL sweep %h*%h: prod=%h held=%h lat=%0d, want %h %0d",
                         a, b, prod, bus.o_PRODUCT, lat, ref_mul(a, b), N);
            end
            #1;
            release_result();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        test_reset();
        test_max();
        test_zero_identity();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
